dma_channel_scheduler: RTL and testbench
========================================

DMA_CHANNEL_SCHEDULER -- requirements
Module: dma_channel_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, the number of requesting channels (legal range 2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, the maximum cycles a transfer may spend waiting for the engine.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_CH  per-channel transfer request.
REQ-006 req_ready  output  NUM_CH  per-channel accept; a request is accepted when valid and ready are both high in one cycle.
REQ-007 req_src  input  NUM_CH x 32  per-channel source byte address.
REQ-008 req_dst  input  NUM_CH x 32  per-channel destination byte address.
REQ-009 req_count  input  NUM_CH x 32  per-channel byte count.
REQ-010 eng_start  output  1  one-cycle start pulse to the shared copy engine.
REQ-011 eng_src / eng_dst / eng_count  output  32 each  latched transfer parameters to the engine.
REQ-012 eng_abort  output  1  one-cycle abort pulse to the engine.
REQ-013 eng_done  input  1  engine completion pulse.
REQ-014 ch_done  output  NUM_CH  one-hot, one-cycle success pulse to the granted channel.
REQ-015 ch_err  output  NUM_CH  one-hot, one-cycle error pulse to the granted channel.
REQ-016 grant_id  output  $clog2(NUM_CH)  index of the channel currently owning the engine.
REQ-017 busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, START, WAIT and FINISH.
REQ-019 In IDLE with any req_valid high, the block SHALL pick a winner round-robin, searching upward from rr_ptr with wrap, and SHALL drive req_ready high for that channel only, combinationally, in the same cycle.
REQ-020 req_ready SHALL be all-zero outside IDLE and when no request is valid.
REQ-021 On accept, the block SHALL latch src, dst, count and grant_id, and SHALL set rr_ptr to (winner+1) mod NUM_CH.
REQ-022 On accept, the next state SHALL be chosen as follows: count==0 -> FINISH with success; any of src[1:0], dst[1:0], count[1:0] nonzero -> FINISH with error; otherwise -> START.
REQ-023 In START, eng_start SHALL be high for exactly one cycle, the wait timer SHALL clear, and the next state SHALL be WAIT.
REQ-024 eng_src, eng_dst and eng_count SHALL hold the latched values, stable from START until the next accept.
REQ-025 In WAIT the timer SHALL increment every cycle, and eng_done SHALL move the state to FINISH with success.
REQ-026 If the timer reaches TIMEOUT-1 without eng_done, the block SHALL pulse eng_abort for one cycle in that cycle and go to FINISH with error.
REQ-027 If eng_done and the timeout occur in the same cycle, eng_done SHALL win: success, no abort.
REQ-028 eng_done outside WAIT SHALL be ignored.
REQ-029 FINISH SHALL last one cycle, SHALL pulse exactly one of ch_done[grant_id] or ch_err[grant_id], and SHALL return to IDLE.
REQ-030 Latency SHALL be: accept in cycle N, eng_start in N+1, earliest done pulse in N+3 (eng_done in N+2), earliest next accept in N+4.
REQ-031 A channel holding req_valid high across consecutive transfers SHALL NOT be granted twice in a row while another channel is requesting.

Reset
REQ-032 On reset, the state SHALL become IDLE, rr_ptr and the timer SHALL clear, latched registers SHALL clear, and every output SHALL be 0.
REQ-033 A reset asserted mid-transfer SHALL abandon the transfer and SHALL emit no ch_done, ch_err or eng_abort for it; the engine shares the reset.

Structure
REQ-034 Package dma_pkg SHALL hold the state enum, the 32-bit address/count width constant and the 4-byte alignment mask.
REQ-035 Sub-module rr_arbiter (parameter NUM_CH; inputs req vector and pointer; outputs one-hot grant, index and any) SHALL implement the winner selection.

Verification
REQ-036 Scenario: ch2 requests src=0x100, dst=0x200, count=16, and eng_done arrives 5 cycles after eng_start -> eng_start one cycle after accept, eng_* = 0x100/0x200/16, ch_done=4'b0100 one cycle after eng_done.
REQ-037 Scenario: all four channels hold req_valid continuously -> grant order 0,1,2,3,0, with each engine done completing its transfer.
REQ-038 Scenario: ch1 requests count=0, and separately ch3 requests src=0x102 -> each gets FINISH without eng_start; ch_done=4'b0010 for ch1, ch_err=4'b1000 for ch3.
REQ-039 Scenario: TIMEOUT=8 and eng_done is never returned -> eng_abort in the 8th WAIT cycle, ch_err on the next cycle.
REQ-040 Scenario: eng_done coincides with the timeout cycle -> ch_done, no eng_abort.
REQ-041 Scenario: reset is asserted during WAIT -> outputs 0 the next cycle, no done/err pulse, and a new request is accepted normally afterwards.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the DMA channel scheduler
package dma_pkg;

  localparam int DATA_W = 32;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_FINISH
  } state_e;

  // A transfer is unusable when any of its byte fields is not word aligned.
  function automatic logic is_misaligned(input logic [1:0] src_lo,
                                         input logic [1:0] dst_lo,
                                         input logic [1:0] count_lo);
    return |((src_lo | dst_lo | count_lo) & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/dma_channel_scheduler_if.sv
// rtl/dma_channel_scheduler_if.sv - channel request and copy-engine bus of the scheduler
interface dma_channel_scheduler_if #(
  parameter int NUM_CH = 4
);
  import dma_pkg::*;

  localparam int IDX_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]             req_valid;
  logic [NUM_CH-1:0]             req_ready;
  logic [NUM_CH-1:0][DATA_W-1:0] req_src;
  logic [NUM_CH-1:0][DATA_W-1:0] req_dst;
  logic [NUM_CH-1:0][DATA_W-1:0] req_count;
  logic                          eng_start;
  logic [DATA_W-1:0]             eng_src;
  logic [DATA_W-1:0]             eng_dst;
  logic [DATA_W-1:0]             eng_count;
  logic                          eng_abort;
  logic                          eng_done;
  logic [NUM_CH-1:0]             ch_done;
  logic [NUM_CH-1:0]             ch_err;
  logic [IDX_W-1:0]              grant_id;
  logic                          busy;

  modport slave (
    input  req_valid, req_src, req_dst, req_count, eng_done,
    output req_ready, eng_start, eng_src, eng_dst, eng_count, eng_abort,
           ch_done, ch_err, grant_id, busy
  );

  modport master (
    output req_valid, req_src, req_dst, req_count, eng_done,
    input  req_ready, eng_start, eng_src, eng_dst, eng_count, eng_abort,
           ch_done, ch_err, grant_id, busy
  );

endinterface

// File: rtl/dma_channel_scheduler_rr_arbiter.sv
// rtl/dma_channel_scheduler_rr_arbiter.sv - round-robin winner selection among requesting channels
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  logic [IDX_W-1:0] cand;

  // Scan upward from ptr with wrap; the first requesting channel wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_CH);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_channel_scheduler.sv
// rtl/dma_channel_scheduler.sv - shares one copy engine among NUM_CH DMA channels
module dma_channel_scheduler
  import dma_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 1024
) (
  input logic                   clk,
  input logic                   reset,
  dma_channel_scheduler_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [NUM_CH-1:0] ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0] src_q, src_d;
  logic [DATA_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic              eng_start_q, eng_start_d;
  logic [NUM_CH-1:0] ch_done_q, ch_done_d;
  logic [NUM_CH-1:0] ch_err_q, ch_err_d;

  logic [NUM_CH-1:0] win_onehot;
  logic [IDX_W-1:0]  win_idx;
  logic              win_any;
  logic              accept;
  logic              timeout_hit;
  logic [NUM_CH-1:0] grant_onehot;
  logic [DATA_W-1:0] sel_src, sel_dst, sel_count;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .grant (win_onehot),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Reset masks the combinational handshake and abort so nothing leaks during reset.
  assign accept       = (state_q == ST_IDLE) && win_any && !reset;
  assign timeout_hit  = (state_q == ST_WAIT) && !bus.eng_done &&
                        (timer_q == TMR_W'(TIMEOUT - 1));
  assign grant_onehot = ONE << grant_q;
  assign sel_src      = bus.req_src[win_idx];
  assign sel_dst      = bus.req_dst[win_idx];
  assign sel_count    = bus.req_count[win_idx];

  assign bus.req_ready = accept ? win_onehot : '0;
  assign bus.eng_abort = timeout_hit && !reset;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_src   = src_q;
  assign bus.eng_dst   = dst_q;
  assign bus.eng_count = count_q;
  assign bus.ch_done   = ch_done_q;
  assign bus.ch_err    = ch_err_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q != ST_IDLE);

  // Next-state and pulse computation; pulses are set on the transition into their state.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    src_d       = src_q;
    dst_d       = dst_q;
    count_d     = count_q;
    grant_d     = grant_q;
    eng_start_d = 1'b0;
    ch_done_d   = '0;
    ch_err_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          src_d    = sel_src;
          dst_d    = sel_dst;
          count_d  = sel_count;
          grant_d  = win_idx;
          rr_ptr_d = (win_idx == IDX_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
          if (sel_count == '0) begin
            state_d   = ST_FINISH;
            ch_done_d = win_onehot;
          end else if (is_misaligned(sel_src[1:0], sel_dst[1:0], sel_count[1:0])) begin
            state_d  = ST_FINISH;
            ch_err_d = win_onehot;
          end else begin
            state_d     = ST_START;
            eng_start_d = 1'b1;
          end
        end
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (bus.eng_done) begin
          state_d   = ST_FINISH;
          ch_done_d = grant_onehot;
        end else if (timeout_hit) begin
          state_d  = ST_FINISH;
          ch_err_d = grant_onehot;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      timer_q     <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      count_q     <= '0;
      grant_q     <= '0;
      eng_start_q <= 1'b0;
      ch_done_q   <= '0;
      ch_err_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      timer_q     <= timer_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      count_q     <= count_d;
      grant_q     <= grant_d;
      eng_start_q <= eng_start_d;
      ch_done_q   <= ch_done_d;
      ch_err_q    <= ch_err_d;
    end
  end

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// tb/tb_dma_channel_scheduler.sv - randomized self-checking bench with a transfer-timeline model
module tb_dma_channel_scheduler;

  localparam int NCH  = 4;
  localparam int TMO  = 8;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic reset;

  dma_channel_scheduler_if #(.NUM_CH(NCH)) bus ();

  dma_channel_scheduler #(.NUM_CH(NCH), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Bench-side channel requests.
  bit   [NCH-1:0] v;
  logic [31:0]    s [NCH];
  logic [31:0]    d [NCH];
  logic [31:0]    c [NCH];
  bit             hold = 0;
  bit             spur = 0;
  int             next_delay = 3;

  // Model: expected per-cycle timeline, filled in when a transfer is accepted.
  int   cyc = 0;
  int   idle_at = 0;
  int   busy_from = 0;
  int   rr = 0;
  logic [31:0] m_src = 0, m_dst = 0, m_cnt = 0;
  int   m_gid = 0;
  bit        e_start   [MAXC];
  bit        e_abort   [MAXC];
  bit [3:0]  e_done    [MAXC];
  bit [3:0]  e_err     [MAXC];
  bit        done_plan [MAXC];
  bit        in_wait   [MAXC];
  int        grants [$];
  bit        acc_flag;
  int        acc_cyc;

  // Observed DUT values, used only for literal spot checks.
  bit        obs_start [MAXC];
  bit        obs_abort [MAXC];
  bit [3:0]  obs_done  [MAXC];
  bit [3:0]  obs_err   [MAXC];
  bit        obs_busy  [MAXC];
  logic [31:0] obs_src [MAXC];
  logic [31:0] obs_dst [MAXC];
  logic [31:0] obs_cnt [MAXC];

  int exp_order [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic accept(input int w);
    int n;
    n = cyc;
    acc_flag = 1;
    acc_cyc  = n;
    grants.push_back(w);
    m_src = s[w]; m_dst = d[w]; m_cnt = c[w]; m_gid = w;
    rr = (w + 1) % NCH;
    busy_from = n + 1;
    if (c[w] == 0) begin
      e_done[n+1] = 4'(1 << w);
      idle_at = n + 2;
    end else if (((s[w] | d[w] | c[w]) & 32'd3) != 0) begin
      e_err[n+1] = 4'(1 << w);
      idle_at = n + 2;
    end else begin
      e_start[n+1] = 1;
      if (next_delay >= 1 && next_delay <= TMO) begin
        done_plan[n+1+next_delay] = 1;
        for (int k = 1; k <= next_delay; k++) in_wait[n+1+k] = 1;
        e_done[n+2+next_delay] = 4'(1 << w);
        idle_at = n + 3 + next_delay;
      end else begin
        for (int k = 1; k <= TMO; k++) in_wait[n+1+k] = 1;
        e_abort[n+1+TMO] = 1;
        e_err[n+2+TMO]   = 4'(1 << w);
        idle_at = n + 3 + TMO;
      end
    end
    if (!hold) v[w] = 0;
  endtask

  task automatic model_reset();
    for (int k = cyc + 1; k < MAXC; k++) begin
      e_start[k] = 0; e_abort[k] = 0; e_done[k] = 0; e_err[k] = 0;
      done_plan[k] = 0; in_wait[k] = 0;
    end
    idle_at = cyc + 1;
    rr = 0;
    m_src = 0; m_dst = 0; m_cnt = 0; m_gid = 0;
  endtask

  // One cycle: drive inputs, compare every output against the model, advance.
  task automatic step();
    logic [3:0] ex_ready;
    int w;
    for (int i = 0; i < NCH; i++) begin
      bus.req_src[i]   = s[i];
      bus.req_dst[i]   = d[i];
      bus.req_count[i] = c[i];
    end
    bus.req_valid = v;
    bus.eng_done  = !reset && (done_plan[cyc] || (spur && !in_wait[cyc]));
    #1;
    w = -1;
    if (!reset && cyc >= idle_at)
      for (int k = 0; k < NCH; k++)
        if (w < 0 && v[(rr + k) % NCH]) w = (rr + k) % NCH;
    ex_ready = (w >= 0) ? 4'(1 << w) : 4'd0;
    chk("req_ready", bus.req_ready, ex_ready);
    chk("eng_start", bus.eng_start, e_start[cyc]);
    chk("eng_abort", bus.eng_abort, reset ? 1'b0 : e_abort[cyc]);
    chk("ch_done",   bus.ch_done,   e_done[cyc]);
    chk("ch_err",    bus.ch_err,    e_err[cyc]);
    chk("busy",      bus.busy,      (cyc >= busy_from && cyc < idle_at));
    chk("eng_src",   bus.eng_src,   m_src);
    chk("eng_dst",   bus.eng_dst,   m_dst);
    chk("eng_count", bus.eng_count, m_cnt);
    chk("grant_id",  bus.grant_id,  m_gid);
    obs_start[cyc] = bus.eng_start;
    obs_abort[cyc] = bus.eng_abort;
    obs_done[cyc]  = bus.ch_done;
    obs_err[cyc]   = bus.ch_err;
    obs_busy[cyc]  = bus.busy;
    obs_src[cyc]   = bus.eng_src;
    obs_dst[cyc]   = bus.eng_dst;
    obs_cnt[cyc]   = bus.eng_count;
    if (reset) model_reset();
    else if (w >= 0) accept(w);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic run_until_accept(input string tag);
    acc_flag = 0;
    for (int k = 0; k < 40 && !acc_flag; k++) step();
    if (!acc_flag) begin
      vectors++;
      miscompares++;
      $display("FAIL %s accept_timeout act=none exp=accept", tag);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] src, input logic [31:0] dst,
                         input logic [31:0] cnt);
    v[i] = 1; s[i] = src; d[i] = dst; c[i] = cnt;
  endtask

  task automatic new_rand_req(input int i);
    int r;
    v[i] = 1;
    s[i] = $urandom & 32'hFFFF_FFFC;
    d[i] = $urandom & 32'hFFFF_FFFC;
    c[i] = 32'($urandom_range(1, 64)) << 2;
    r = $urandom_range(0, 15);
    if (r == 0)      c[i] = 0;
    else if (r == 1) s[i][1:0] = 2'($urandom_range(1, 3));
    else if (r == 2) d[i][0] = 1'b1;
    else if (r == 3) c[i][1] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "simulation stalled");
  end

  initial begin
    int n, n1, n3, n2;
    bit [3:0] acc_or;
    reset = 1;
    v = '0;
    for (int i = 0; i < NCH; i++) begin s[i] = 0; d[i] = 0; c[i] = 0; end
    bus.req_valid = '0;
    bus.eng_done  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      bus.req_src[i] = '0; bus.req_dst[i] = '0; bus.req_count[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;

    // Reset state.
    step();
    chk("rst_busy", obs_busy[0], 1'b0);
    chk("rst_src",  obs_src[0],  32'h0);
    chk("rst_done", obs_done[0], 4'h0);
    run(2);

    // All four channels request continuously: order 0,1,2,3,0.
    grants.delete();
    hold = 1; next_delay = 3;
    for (int i = 0; i < NCH; i++) set_req(i, 32'h1000 * (i + 1), 32'h8000 + 32'h10 * i, 32'd16);
    for (int k = 0; k < 80 && grants.size() < 5; k++) step();
    v = '0; hold = 0;
    run(10);
    chk("order_len", grants.size(), 5);
    for (int i = 0; i < 5; i++) chk("order", grants[i], exp_order[i]);

    // ch2 single transfer, engine done 5 cycles after start.
    set_req(2, 32'h100, 32'h200, 32'd16);
    next_delay = 5;
    run_until_accept("ch2_basic");
    n = acc_cyc;
    run(10);
    chk("basic_start", obs_start[n+1], 1'b1);
    chk("basic_src",   obs_src[n+1],   32'h100);
    chk("basic_dst",   obs_dst[n+1],   32'h200);
    chk("basic_cnt",   obs_cnt[n+1],   32'd16);
    chk("basic_early", obs_done[n+6],  4'h0);
    chk("basic_done",  obs_done[n+7],  4'b0100);

    // Zero count and misaligned source finish without the engine.
    set_req(1, 32'h40, 32'h80, 32'd0);
    run_until_accept("ch1_zero");
    n1 = acc_cyc;
    run(3);
    set_req(3, 32'h102, 32'h200, 32'd16);
    run_until_accept("ch3_misal");
    n3 = acc_cyc;
    run(3);
    chk("zero_done",   obs_done[n1+1],  4'b0010);
    chk("zero_start",  obs_start[n1+1], 1'b0);
    chk("misal_err",   obs_err[n3+1],   4'b1000);
    chk("misal_start", obs_start[n3+1], 1'b0);

    // Engine never answers: abort in the 8th WAIT cycle, error after.
    set_req(0, 32'h300, 32'h400, 32'd8);
    next_delay = 0;
    run_until_accept("timeout");
    n = acc_cyc;
    run(12);
    chk("tmo_no_abort", obs_abort[n+8],  1'b0);
    chk("tmo_abort",    obs_abort[n+9],  1'b1);
    chk("tmo_err",      obs_err[n+10],   4'b0001);

    // Done arrives in the timeout cycle: success wins.
    set_req(0, 32'h500, 32'h600, 32'd4);
    next_delay = TMO;
    run_until_accept("tie");
    n = acc_cyc;
    run(12);
    chk("tie_abort", obs_abort[n+9], 1'b0);
    chk("tie_done",  obs_done[n+10], 4'b0001);

    // Reset during WAIT, then a normal transfer.
    set_req(1, 32'h700, 32'h800, 32'd12);
    next_delay = 0;
    run_until_accept("pre_reset");
    n = acc_cyc;
    run(3);
    reset = 1;
    step();
    reset = 0;
    run(10);
    acc_or = '0;
    for (int k = n + 4; k <= n + 14; k++) acc_or = acc_or | obs_done[k] | obs_err[k] | 4'(obs_abort[k]);
    chk("rst_quiet", acc_or, 4'h0);
    chk("rst_busy2", obs_busy[n+5], 1'b0);
    chk("rst_src2",  obs_src[n+5],  32'h0);
    set_req(2, 32'h900, 32'hA00, 32'd20);
    next_delay = 2;
    run_until_accept("post_reset");
    n2 = acc_cyc;
    run(8);
    chk("post_done", obs_done[n2+4], 4'b0100);

    // Randomized traffic.
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < NCH; i++)
        if (!v[i] && $urandom_range(0, 3) == 0) new_rand_req(i);
      next_delay = $urandom_range(0, 10);
      hold = ($urandom_range(0, 1) == 1);
      spur = ($urandom_range(0, 4) == 0);
      reset = in_wait[cyc] && !done_plan[cyc] && ($urandom_range(0, 99) == 0);
      step();
      reset = 0;
    end
    v = '0; hold = 0; spur = 0;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
